// File: rtl/fast_corner_collector.sv
// Collects post-NMS corner coordinates into a FWFT FIFO, tagging the last corner of each
// frame or inserting an empty-frame marker; read out over a valid/ready handshake.
module fast_corner_collector #(
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     iscorner,
    input  logic [X_W-1:0]           x_coord,
    input  logic [Y_W-1:0]           y_coord,
    input  logic                     frame_end,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [X_W-1:0]           m_x,
    output logic [Y_W-1:0]           m_y,
    output logic                     m_last,
    output logic                     m_empty,
    output logic [CNT_W-1:0]         frame_corners,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = X_W + Y_W + 2;

    // stage register in front of the FIFO
    logic             r_stg_vld;
    logic [X_W-1:0]   r_stg_x;
    logic [Y_W-1:0]   r_stg_y;
    logic             r_stg_last;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_m_valid;
    logic [EW-1:0]    r_head;

    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_frame_corners;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_overflow;

    logic             w_full;
    logic             w_new;
    logic             w_fe;
    logic             w_stg_push;
    logic             w_stg_free;
    logic             w_load;
    logic             w_drop;
    logic             w_mark_req;
    logic             w_mark_push;
    logic             w_fe_lost;
    logic             w_push;
    logic [EW-1:0]    w_push_data;
    logic             w_pop;
    logic [LW-1:0]    w_level_nxt;
    logic [LW-1:0]    w_remain;
    logic [AW-1:0]    w_rd_nxt;
    logic [EW-1:0]    w_head_nxt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_full      = (r_level == LW'(DEPTH));
    assign w_new       = ce & iscorner;
    assign w_fe        = ce & frame_end;
    assign w_stg_push  = ce & r_stg_vld & ~w_full & (r_stg_last | w_new);
    assign w_stg_free  = ~r_stg_vld | w_stg_push;
    assign w_load      = w_new & w_stg_free;
    assign w_drop      = w_new & ~w_stg_free;
    assign w_mark_req  = w_fe & ~w_new & ~r_stg_vld & (r_frame_cnt == '0);
    assign w_mark_push = w_mark_req & ~w_full;
    // a frame_end arriving while the previous frame's last corner is still staged cannot be recorded
    assign w_fe_lost   = (w_mark_req & w_full) | (w_fe & ~w_new & r_stg_vld & r_stg_last);
    assign w_push      = w_stg_push | w_mark_push;
    assign w_pop       = r_m_valid & m_ready;
    assign w_cnt_inc   = (w_new && (r_frame_cnt != {CNT_W{1'b1}})) ? r_frame_cnt + CNT_W'(1) : r_frame_cnt;

    // FIFO next-state: occupancy, read pointer and the entry that will sit at the output
    always_comb begin
        w_push_data = '0;
        w_level_nxt = r_level;
        w_remain    = r_level;
        w_rd_nxt    = r_rd_ptr;
        w_head_nxt  = r_head;
        if (w_mark_push) begin
            w_push_data = {{X_W{1'b0}}, {Y_W{1'b0}}, 1'b1, 1'b1};
        end else begin
            w_push_data = {r_stg_x, r_stg_y, r_stg_last, 1'b0};
        end
        if (w_pop) begin
            w_remain = r_level - LW'(1);
            w_rd_nxt = r_rd_ptr + AW'(1);
        end else begin
            w_remain = r_level;
            w_rd_nxt = r_rd_ptr;
        end
        if (w_push) begin
            w_level_nxt = w_remain + LW'(1);
        end else begin
            w_level_nxt = w_remain;
        end
        // with nothing left behind the head, the incoming entry falls straight through
        if (w_remain == '0) begin
            w_head_nxt = w_push_data;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // FIFO pointers, occupancy and registered output entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_m_valid <= 1'b0;
            r_head    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr  <= w_rd_nxt;
            r_level   <= w_level_nxt;
            r_m_valid <= (w_level_nxt != '0);
            r_head    <= w_head_nxt;
        end
    end

    // stage register load / release / last-tagging
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_vld  <= 1'b0;
            r_stg_x    <= '0;
            r_stg_y    <= '0;
            r_stg_last <= 1'b0;
        end else if (w_load) begin
            r_stg_vld  <= 1'b1;
            r_stg_x    <= x_coord;
            r_stg_y    <= y_coord;
            r_stg_last <= frame_end;
        end else if (w_stg_push) begin
            r_stg_vld  <= 1'b0;
            r_stg_last <= 1'b0;
        end else if (w_fe && r_stg_vld && !r_stg_last) begin
            r_stg_last <= 1'b1;
        end
    end

    // per-frame counting, drop counting and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt     <= '0;
            r_frame_corners <= '0;
            r_drop_cnt      <= '0;
            r_overflow      <= 1'b0;
        end else begin
            if (w_fe) begin
                r_frame_corners <= w_cnt_inc;
                r_frame_cnt     <= '0;
            end else begin
                r_frame_cnt     <= w_cnt_inc;
            end
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            if (w_drop || w_fe_lost) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign m_valid       = r_m_valid;
    assign {m_x, m_y, m_last, m_empty} = r_head;
    assign level         = r_level;
    assign frame_corners = r_frame_corners;
    assign drop_cnt      = r_drop_cnt;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_fast_corner_collector.sv
// Scoreboard bench for fast_corner_collector (DEPTH=4): expected entries are queued as
// stimulus is driven and compared as the DUT hands them out.
module tb_fast_corner_collector;

    localparam int X_W   = 10;
    localparam int Y_W   = 10;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int EW    = X_W + Y_W + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ce = 1'b1;
    logic             iscorner = 1'b0;
    logic [X_W-1:0]   x_coord = '0;
    logic [Y_W-1:0]   y_coord = '0;
    logic             frame_end = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [X_W-1:0]   m_x;
    logic [Y_W-1:0]   m_y;
    logic             m_last;
    logic             m_empty;
    logic [CNT_W-1:0] frame_corners;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;
    logic [$clog2(DEPTH):0] level;

    int n_chk = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    fast_corner_collector #(.X_W(X_W), .Y_W(Y_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .iscorner(iscorner), .x_coord(x_coord),
        .y_coord(y_coord), .frame_end(frame_end), .m_valid(m_valid), .m_ready(m_ready),
        .m_x(m_x), .m_y(m_y), .m_last(m_last), .m_empty(m_empty),
        .frame_corners(frame_corners), .drop_cnt(drop_cnt), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input int x, input int y, input logic last, input logic emp);
        return {X_W'(x), Y_W'(y), last, emp};
    endfunction

    // one capture-side pixel, consumed on the next rising edge
    task automatic pix(input logic c, input int x, input int y, input logic fe);
        iscorner  = c;
        x_coord   = X_W'(x);
        y_coord   = Y_W'(y);
        frame_end = fe;
        @(posedge clk); #1;
        iscorner  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        idle(2);
        check_val("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // output monitor: handshake seen here completes on the following rising edge
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_entry", 32'({m_x, m_y, m_last, m_empty}), 32'hFFFF_FFFF);
            end else begin
                check_val("entry", 32'({m_x, m_y, m_last, m_empty}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [X_W-1:0] hx;
        logic [Y_W-1:0] hy;
        idle(2);
        rst = 1'b0;
        check_val("rst_valid", 32'(m_valid), 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_drop", 32'(drop_cnt), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);

        // basic frame, three corners
        m_ready = 1'b1;
        exp_q.push_back(ent(3, 2, 1'b0, 1'b0));
        exp_q.push_back(ent(7, 5, 1'b0, 1'b0));
        exp_q.push_back(ent(12, 9, 1'b1, 1'b0));
        pix(1'b1, 3, 2, 1'b0);
        pix(1'b1, 7, 5, 1'b0);
        pix(1'b1, 12, 9, 1'b0);
        pix(1'b0, 0, 0, 1'b1);
        drain(20);
        check_val("t1_fc", 32'(frame_corners), 32'd3);
        check_val("t1_ovf", 32'(overflow), 32'd0);

        // empty frame marker
        exp_q.push_back(ent(0, 0, 1'b1, 1'b1));
        pix(1'b0, 0, 0, 1'b1);
        drain(20);
        check_val("t2_fc", 32'(frame_corners), 32'd0);

        // corner coincident with frame_end, then a two-corner frame
        exp_q.push_back(ent(20, 10, 1'b1, 1'b0));
        pix(1'b1, 20, 10, 1'b1);
        check_val("t3_fc", 32'(frame_corners), 32'd1);
        exp_q.push_back(ent(1, 1, 1'b0, 1'b0));
        exp_q.push_back(ent(2, 2, 1'b1, 1'b0));
        pix(1'b1, 1, 1, 1'b0);
        pix(1'b1, 2, 2, 1'b0);
        pix(1'b0, 0, 0, 1'b1);
        drain(20);
        check_val("t3_fc2", 32'(frame_corners), 32'd2);

        // back-pressure: 4 in FIFO, corner 5 staged, corners 6..8 dropped
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            pix(1'b1, i, 2 * i, 1'b0);
        end
        pix(1'b0, 0, 0, 1'b1);
        idle(2);
        check_val("t4_level", 32'(level), 32'd4);
        check_val("t4_valid", 32'(m_valid), 32'd1);
        check_val("t4_drop", 32'(drop_cnt), 32'd3);
        check_val("t4_ovf", 32'(overflow), 32'd1);
        check_val("t4_fc", 32'(frame_corners), 32'd8);
        hx = m_x;
        hy = m_y;
        idle(3);
        check_val("t4_hold_x", 32'(m_x), 32'(hx));
        check_val("t4_hold_y", 32'(m_y), 32'(hy));
        check_val("t4_head", 32'({m_x, m_y, m_last, m_empty}), 32'(ent(1, 2, 1'b0, 1'b0)));
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(ent(i, 2 * i, (i == 5), 1'b0));
        end
        m_ready = 1'b1;
        drain(30);

        // clock enable low: everything ignored
        ce = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pix(1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023), (i == 4));
        end
        check_val("t5_level", 32'(level), 32'd0);
        check_val("t5_valid", 32'(m_valid), 32'd0);
        check_val("t5_fc", 32'(frame_corners), 32'd8);
        check_val("t5_drop", 32'(drop_cnt), 32'd3);
        ce = 1'b1;
        exp_q.push_back(ent(5, 6, 1'b1, 1'b0));
        pix(1'b1, 5, 6, 1'b0);
        pix(1'b0, 0, 0, 1'b1);
        drain(20);
        check_val("t5_fc2", 32'(frame_corners), 32'd1);

        // reset mid-frame with FIFO and stage occupied
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            pix(1'b1, 10, i, 1'b0);
        end
        idle(1);
        check_val("t6_level_pre", 32'(level), 32'd3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_val("t6_valid", 32'(m_valid), 32'd0);
        check_val("t6_level", 32'(level), 32'd0);
        check_val("t6_drop", 32'(drop_cnt), 32'd0);
        check_val("t6_ovf", 32'(overflow), 32'd0);
        check_val("t6_fc", 32'(frame_corners), 32'd0);
        m_ready = 1'b1;
        idle(3);
        check_val("t6_stage_gone", 32'(m_valid), 32'd0);
        exp_q.push_back(ent(9, 9, 1'b1, 1'b0));
        pix(1'b1, 9, 9, 1'b0);
        pix(1'b0, 0, 0, 1'b1);
        drain(20);
        check_val("t6_fc2", 32'(frame_corners), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fast_corner_collector.md
Name: fast_corner_collector

Overview:
- Sink for the corner detector's output stream. Consumes the per-pixel iscorner/x_coord/y_coord signals and captures each detected corner's coordinates.
- Tags the last corner of every frame, or emits an explicit empty-frame marker when a frame has no corners.
- Buffers entries in a first-word-fall-through FIFO, read out over a valid/ready handshake.
- Sits between FAST_with_NMS and downstream descriptor/host logic; also used in benches as the checker-side reader of detector results.

Parameters:
- X_W, 10, width of x coordinate
- Y_W, 10, width of y coordinate
- DEPTH, 64, FIFO entries; power of 2, >= 4
- CNT_W, 16, width of per-frame corner counter and drop counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ce  in  1  clock enable for the capture side; readout side ignores ce
- iscorner  in  1  current pixel is a corner (post-NMS)
- x_coord  in  X_W  corner column
- y_coord  in  Y_W  corner row
- frame_end  in  1  single-cycle pulse, last pixel of frame
- m_valid  out  1  output entry valid
- m_ready  in  1  consumer accepts entry
- m_x  out  X_W  entry column
- m_y  out  Y_W  entry row
- m_last  out  1  entry is last of its frame
- m_empty  out  1  entry is empty-frame marker; m_x/m_y = 0
- frame_corners  out  CNT_W  corners seen in last completed frame, stored + dropped
- drop_cnt  out  CNT_W  total corners dropped since reset; saturates at all-ones
- overflow  out  1  sticky; set on any drop or lost marker; cleared only by rst
- level  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (clk edge with rst=1): FIFO, stage, counters and all outputs go to 0. Reset mid-frame discards all buffered entries and the stage.
- Capture is active only when ce=1. With ce=0, iscorner and frame_end are ignored and the stage does not push.
- Stage register: one entry {x, y, last} plus an occupied bit, placed in front of the FIFO.
- Stage push: occurs when the stage is occupied, the FIFO is not full, and either stage.last=1 or a new corner arrives this cycle. The pushed entry carries stage.last.
- New corner (ce & iscorner), stage free or pushing this cycle: stage loads {x_coord, y_coord, last=frame_end}, occupied=1. frame_cnt increments.
- New corner, stage blocked (occupied and FIFO full): corner is dropped. drop_cnt and frame_cnt increment; overflow=1.
- frame_end without iscorner:
  - Stage occupied with last=0: set stage.last. It pushes on a following cycle.
  - Stage empty and frame_cnt=0: push marker {0, 0, last=1, empty=1} directly. If the FIFO is full, the marker is lost and overflow=1.
  - Stage occupied with last=1 (previous frame still blocked): the frame_end is lost and overflow=1.
- Any frame_end: frame_corners <= frame_cnt (including a corner in that same cycle); frame_cnt <= 0.
- Capture latency: a corner appears at the FIFO input at the earliest on the cycle the next corner or frame_end arrives, plus 1 clk. m_valid rises 1 clk after the push on an empty FIFO.
- FIFO:
  - Registered outputs, first-word-fall-through.
  - Pop when m_valid & m_ready. m_x, m_y, m_last and m_empty stay stable while m_valid=1 and m_ready=0.
  - Push is blocked when level=DEPTH, even if a pop happens the same cycle.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo DEPTH.
- Counters: frame_cnt saturates at all-ones. drop_cnt saturates.

Test Plan:
1. Corners at (3,2), (7,5), (12,9), then frame_end on an idle pixel, m_ready=1 -> three entries in order; last=1 only on (12,9); frame_corners=3; overflow=0.
2. Frame with no corners, frame_end -> one entry, m_empty=1, m_last=1, m_x=m_y=0; frame_corners=0.
3. Corner (20,10) in the same cycle as frame_end -> single entry (20,10) with last=1, then next-frame corner (1,1) with last=0 after its own frame_end flagging.
4. m_ready=0, DEPTH=4, 8 corners plus frame_end -> level=4, m_valid held with stable data; drop_cnt=3; overflow=1; frame_corners=8; stage holds corner 5 flagged last; after m_ready=1, 5 entries with the last flag on corner 5.
5. ce=0 for 10 cycles with iscorner=1 -> no entries, counters unchanged; ce=1 resumes capture.
6. rst asserted with level=3 and stage occupied -> next cycle m_valid=0, level=0, drop_cnt=0, overflow=0; new frame captures normally.
